// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Brief    : 8-way round-robin arbiter with per-grant hold limit and a
//            forced-release (timeout) pulse. All outputs are registered.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] c_S_IDLE    = 1'b0;
    localparam logic [0:0] c_S_GRANT   = 1'b1;
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [2:0]  r_ptr;
    logic [2:0]  w_ptr_nxt;
    logic [7:0]  r_hold;
    logic [7:0]  w_hold_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_grant;
    logic [7:0]  w_grant_nxt;
    logic        r_valid;
    logic        r_timeout;
    logic        w_timeout_nxt;

    logic [15:0] w_req_dbl;
    logic [7:0]  w_req_rot;
    logic [2:0]  w_pick_off;
    logic        w_pick_found;
    logic [2:0]  w_pick_idx;
    logic        w_owner_req;
    logic        w_at_limit;

    // Rotate so that bit 0 of w_req_rot corresponds to requester r_ptr.
    assign w_req_dbl = {req, req} >> r_ptr;
    assign w_req_rot = w_req_dbl[7:0];

    always_comb begin
        w_pick_off   = 3'd0;
        w_pick_found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_off   = 3'(k);
                w_pick_found = 1'b1;
            end
        end
    end

    assign w_pick_idx  = r_ptr + w_pick_off;
    assign w_owner_req = req[r_idx];
    assign w_at_limit  = (r_hold == c_HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_idx_nxt     = r_idx;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_idx_nxt  = 3'd0;
                w_hold_nxt = 8'd0;
                if (en && w_pick_found) begin
                    w_state_nxt = c_S_GRANT;
                    w_idx_nxt   = w_pick_idx;
                    w_ptr_nxt   = w_pick_idx + 3'd1;
                end
            end
            c_S_GRANT: begin
                if (done || !w_owner_req || w_at_limit) begin
                    w_state_nxt   = c_S_IDLE;
                    w_idx_nxt     = 3'd0;
                    w_hold_nxt    = 8'd0;
                    // Only a pure hold-limit release is reported as a timeout.
                    w_timeout_nxt = w_at_limit && !done && w_owner_req;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_idx_nxt   = 3'd0;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    always_comb begin
        w_grant_nxt = 8'h00;
        if (w_state_nxt == c_S_GRANT) begin
            w_grant_nxt = 8'h01 << w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_ptr     <= 3'd0;
            r_hold    <= 8'd0;
            r_idx     <= 3'd0;
            r_grant   <= 8'h00;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_idx     <= w_idx_nxt;
            r_grant   <= w_grant_nxt;
            r_valid   <= (w_state_nxt == c_S_GRANT);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Brief    : Vector-table, directed and randomized checks of rr_arbiter8
//            against an owner/pointer reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_checks;
    int n_errors;

    // Reference model: owner index (-1 = none), next search start, cycles held.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    typedef struct packed {
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(bit e, bit [7:0] r, bit d);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (e && r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (m_ptr + k) % 8;
                    if (r[c]) begin
                        m_owner = c;
                        m_ptr   = (c + 1) % 8;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else begin
            if (d || !r[m_owner] || m_held == MH) begin
                m_to    = (m_held == MH) && !d && r[m_owner];
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end
    endfunction

    task automatic check_model();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("model_grant", grant, eg);
        chk("model_idx", grant_idx, (m_owner >= 0) ? m_owner : 0);
        chk("model_valid", grant_valid, m_owner >= 0);
        chk("model_timeout", timeout, m_to);
        chk("onehot0", $onehot0(grant), 1);
    endtask

    // Drive inputs away from the edge, clock once, then compare #1 after.
    task automatic apply(input logic e, input logic [7:0] r, input logic d);
        en   = e;
        req  = r;
        done = d;
        @(posedge clk);
        model_step(e, r, d);
        #1;
        check_model();
    endtask

    task automatic expect_out(input string name, input logic [7:0] g, input logic [2:0] idx,
                              input logic v, input logic to);
        chk({name, "_grant"}, grant, g);
        chk({name, "_idx"}, grant_idx, idx);
        chk({name, "_valid"}, grant_valid, v);
        chk({name, "_timeout"}, timeout, to);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        expect_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic e, input logic [7:0] r, input logic d,
                       input logic [7:0] g, input logic [2:0] idx, input logic v, input logic to);
        vec_t x;
        x.en = e; x.req = r; x.done = d; x.g = g; x.idx = idx; x.v = v; x.to = to;
        tbl.push_back(x);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();

        // Round-robin walk with wrap, then hold-limit timeout and done at the limit.
        add(1, 8'hA0, 0, 8'h20, 3'd5, 1, 0);
        add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 0, 8'h40, 3'd6, 1, 0);
        add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
        add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
        add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 0, 8'h02, 3'd1, 1, 0);
        add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h00, 3'd0, 0, 1);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'h00, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        add(0, 8'h08, 1, 8'h00, 3'd0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].req, tbl[i].done);
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].idx, tbl[i].v, tbl[i].to);
        end

        // en gating: blocked in idle, ignored while a grant is held.
        do_reset();
        apply(0, 8'h11, 0); expect_out("en_off0", 8'h00, 3'd0, 0, 0);
        apply(0, 8'h11, 0); expect_out("en_off1", 8'h00, 3'd0, 0, 0);
        apply(1, 8'h11, 0); expect_out("en_on",   8'h01, 3'd0, 1, 0);
        apply(0, 8'h11, 0); expect_out("en_mid0", 8'h01, 3'd0, 1, 0);
        apply(0, 8'h11, 0); expect_out("en_mid1", 8'h01, 3'd0, 1, 0);
        apply(0, 8'h11, 1); expect_out("en_done", 8'h00, 3'd0, 0, 0);
        apply(0, 8'h11, 0); expect_out("en_idle", 8'h00, 3'd0, 0, 0);

        // Asynchronous reset mid-grant, then pointer restarts at 0.
        do_reset();
        apply(1, 8'h04, 0); expect_out("pre_rst0", 8'h04, 3'd2, 1, 0);
        apply(1, 8'h04, 0); expect_out("pre_rst1", 8'h04, 3'd2, 1, 0);
        do_reset();
        apply(1, 8'h84, 0); expect_out("post_rst", 8'h04, 3'd2, 1, 0);

        // Randomized run against the reference model.
        begin
            logic [7:0] r;
            r = 8'h00;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom());
                end
                apply($urandom_range(0, 9) != 0, r, $urandom_range(0, 7) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
